if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Decoupling buffer between the fetch stage and the decode stage of the 16-bit pipelined core. It captures each fetched {instruction, next-PC} pair, holds it while decode stalls, and presents it to decode. On a taken branch it discards wrong-path words and drives a NOP, so decode never sees a bubble as a real instruction. It replaces the ad-hoc output flops in fetch with a proper valid/ready handshake on both sides.

## Interface
Parameters:
- DEPTH, 2, number of entries (2 with skid, forced to 1 without; see Configuration)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  taken branch/redirect from execute; drop all held and incoming words
- in_valid  in  1  fetch presents a word this cycle
- in_instr  in  16  fetched instruction
- in_nextPc  in  16  PC+2 of that instruction
- in_ready  out  1  buffer accepts a word this cycle; fetch holds its PC when low
- out_valid  out  1  head entry is a real instruction
- out_instr  out  16  head instruction; 16'h0800 (NOP) when out_valid=0
- out_nextPc  out  16  head next-PC; 16'h0000 when out_valid=0
- out_ready  in  1  decode consumes the head this cycle (low = decode stall)
- count  out  2  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH slots, write pointer, read pointer, and occupancy counter.
- Push happens when in_valid & in_ready. Pop happens when out_valid & out_ready.
- in_ready = (count < DEPTH). It depends only on registered state, with no path from out_ready.
- out_valid = (count != 0). out_instr/out_nextPc are read from the head slot when valid; otherwise they are forced to NOP/0.
- Push only: the word is written to the wptr slot, wptr advances (wraps DEPTH-1 -> 0), and count increments.
- Pop only: rptr advances with wrap and count decrements.
- Push and pop together: both pointers advance and count is unchanged. When count=DEPTH there is no push because in_ready=0.
- Flush has priority over push and pop:
  - count <- 0 and wptr <- rptr.
  - The word offered in the flush cycle is discarded.
  - The head is not counted as consumed even if out_ready=1. Decode must itself squash the instruction it took that cycle.
- Slot contents are not cleared on pop or flush. Only count gates validity.
- Reset (rst=0, async): count=0, pointers=0, out_valid=0, out_instr=16'h0800, out_nextPc=0, in_ready=1.
- Reset deasserted mid-stream: the first accepted word is the first one offered after rst rises.

## Timing
- Latency: a word pushed at edge N is on out_* (out_valid=1) from edge N until it is popped.
- Throughput is one word per cycle when out_ready=1 continuously. There are no bubbles at steady state.
- A decode stall of k cycles with DEPTH=2 absorbs 2 words. in_ready falls the cycle after the second push.
- After out_ready rises on a full buffer, in_ready rises one edge later (after the first pop).
- Flush at edge N: out_valid=0 and out_instr=16'h0800 from edge N. A push is accepted at edge N+1 if in_valid.

## Configuration
- IFID_SKID_EN defined: DEPTH=2 as above, with no combinational out_ready -> in_ready path.
- IFID_SKID_EN undefined: DEPTH=1 plain pipeline register.
  - in_ready = (count==0) | out_ready. This is a combinational path, allowed only in this mode.
  - Simultaneous push and pop replace the single entry.
  - Flush, reset, and NOP behaviour are identical.

## Structure
- Shared package pipe_pkg:
  - NOP_INSTR = 16'h0800
  - INSTR_W = 16, PC_W = 16
  - type ifid_word_t = {instr, nextPc}
- One sub-module, ifid_slot: a 32-bit storage slot with write enable, built from the existing dff cells, reset to {NOP_INSTR, 16'h0}.
- The top level holds the pointers, the counter, and the output muxing.

## Test plan
- Reset: hold rst=0 three cycles with in_valid=1 -> out_valid=0, out_instr=16'h0800, count=0, in_ready=1.
- Streaming: push 0x1111..0x5555 on consecutive cycles with out_ready=1 -> each appears one edge after its push, in order, with no gap.
- Stall: out_ready=0 while pushing 0xA001, 0xA002, 0xA003 (SKID) -> count=2, in_ready=0 at edge 3, 0xA003 not accepted. Raise out_ready -> outputs 0xA001 then 0xA002, and in_ready returns after the first pop.
- Flush on full buffer with in_valid=1 (0xB000) and out_ready=1 -> next cycle count=0, out_instr=16'h0800. 0xB000 never appears, and the next offered 0xC000 is output normally.
- Pointer wrap: 10 push/pop pairs with count held at 1 -> data order preserved across wraps and out_nextPc matches each pushed value.
- IFID_SKID_EN undefined: out_ready=1, in_valid=1 on a full entry -> in_ready=1 in the same cycle and the entry is replaced at the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 16-bit core: instruction/PC widths, NOP
// encoding and the {instr, nextPc} word that travels from fetch to decode.
package pipe_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    nextPc;
  } ifid_word_t;

  localparam ifid_word_t RESET_WORD = '{instr: NOP_INSTR, nextPc: 16'h0000};

  // Decode must never see stale slot data as an instruction, so an invalid
  // head is replaced by the architectural NOP with a zero next-PC.
  function automatic ifid_word_t word_or_nop(input logic valid, input ifid_word_t w);
    if (valid) begin
      return w;
    end else begin
      return RESET_WORD;
    end
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// The buffer uses the slave modport; its driver (fetch/decode/bench) uses master.
interface if_id_buffer_if;
  import pipe_pkg::*;

  logic               flush;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_nextPc;
  logic               in_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_nextPc;
  logic               out_ready;
  logic [1:0]         count;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  in_nextPc,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_nextPc,
    input  out_ready,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output in_nextPc,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_nextPc,
    output out_ready,
    input  count
  );

endinterface

// File: rtl/ifid_slot.sv
// One 32-bit {instr, nextPc} storage slot with write enable, reset to a NOP
// word so an uninitialised slot can never leak a real-looking instruction.
module ifid_slot
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  ifid_word_t d_i,
  output ifid_word_t q_o
);

  ifid_word_t word_q;

  // Slot storage register; contents survive pops and flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= RESET_WORD;
    end else if (we_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: circular buffer of {instr, nextPc} words with
// valid/ready on both sides and flush-to-NOP. IFID_SKID_EN selects the
// two-entry skid buffer; without it a single pipeline register is built.
module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  if_id_buffer_if.slave  bus
);

`ifdef IFID_SKID_EN
  localparam int DEPTH_EFF = DEPTH;
`else
  // Plain pipeline register: always a single entry whatever DEPTH says.
  localparam int DEPTH_EFF = (DEPTH > 0) ? 1 : 1;
`endif

  localparam int               PTR_W     = (DEPTH_EFF > 1) ? $clog2(DEPTH_EFF) : 1;
  localparam logic [1:0]       DEPTH_CNT = 2'(DEPTH_EFF);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH_EFF - 1);

  logic [1:0]       count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;
  logic             out_valid_s;
  ifid_word_t       wr_word_s;
  ifid_word_t       head_s;
  logic [$bits(ifid_word_t)-1:0] head_bits_s;
  ifid_word_t       slot_s [DEPTH_EFF];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign out_valid_s = (count_q != 2'd0);

`ifdef IFID_SKID_EN
  // Registered-only ready: no combinational path from out_ready.
  assign in_ready_s = (count_q < DEPTH_CNT);
`else
  assign in_ready_s = (count_q == 2'd0) | bus.out_ready;
`endif

  // Flush wins: neither the offered word nor the head is taken that cycle.
  assign push_s = bus.in_valid & in_ready_s & ~bus.flush;
  assign pop_s  = out_valid_s & bus.out_ready & ~bus.flush;

  assign wr_word_s = '{instr: bus.in_instr, nextPc: bus.in_nextPc};

  // Pointer and occupancy next-state.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (bus.flush) begin
      count_d = 2'd0;
      wptr_d  = rptr_q;
    end else begin
      if (push_s) begin
        wptr_d = ptr_inc(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ptr_inc(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  for (genvar i = 0; i < DEPTH_EFF; i++) begin : g_slot
    ifid_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .we_i (push_s && (wptr_q == PTR_W'(i))),
      .d_i  (wr_word_s),
      .q_o  (slot_s[i])
    );
  end

  // Head select as an AND-OR mux over the slots keyed by the read pointer.
  always_comb begin
    head_bits_s = '0;
    for (int i = 0; i < DEPTH_EFF; i++) begin
      head_bits_s = head_bits_s |
                    (slot_s[i] & {$bits(ifid_word_t){rptr_q == PTR_W'(i)}});
    end
  end

  assign head_s = ifid_word_t'(head_bits_s);

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_instr  = word_or_nop(out_valid_s, head_s).instr;
  assign bus.out_nextPc = word_or_nop(out_valid_s, head_s).nextPc;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer; adapts its expectations to
// the IFID_SKID_EN build (two-entry skid) or the default single-entry build.
module tb_if_id_buffer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  if_id_buffer_if bus ();

  if_id_buffer #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_nextPc = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h5678);
    repeat (3) tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_instr !== 16'h0800) begin bad++; $display("FAIL reset_out_instr got=%h exp=0800", bus.out_instr); end
    total++; if (bus.out_nextPc !== 16'h0000) begin bad++; $display("FAIL reset_out_nextPc got=%h exp=0000", bus.out_nextPc); end
    total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL post_reset_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_streaming();
    logic [15:0] w;
    logic [15:0] pc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w  = 16'h1111 * 16'(k + 1);
      pc = 16'h0100 + 16'(2 * k);
      drive(1'b1, w, pc);
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, bus.out_valid); end
      total++; if (bus.out_instr !== w) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, bus.out_instr, w); end
      total++; if (bus.out_nextPc !== pc) begin bad++; $display("FAIL stream_nextPc[%0d] got=%h exp=%h", k, bus.out_nextPc, pc); end
      total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, bus.count); end
    end
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_instr !== 16'h0800) begin bad++; $display("FAIL stream_drain_nop got=%h exp=0800", bus.out_instr); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hA001, 16'h0A02);
    tick();
    total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL stall_count1 got=%0d exp=1", bus.count); end
    total++; if (bus.out_instr !== 16'hA001) begin bad++; $display("FAIL stall_head1 got=%h exp=a001", bus.out_instr); end
`ifdef IFID_SKID_EN
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1 got=%b exp=1", bus.in_ready); end
    drive(1'b1, 16'hA002, 16'h0A04);
    tick();
    total++; if (bus.count !== 2'd2) begin bad++; $display("FAIL stall_count2 got=%0d exp=2", bus.count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready2 got=%b exp=0", bus.in_ready); end
    drive(1'b1, 16'hA003, 16'h0A06);
    tick();
    total++; if (bus.count !== 2'd2) begin bad++; $display("FAIL stall_count3 got=%0d exp=2", bus.count); end
    total++; if (bus.out_instr !== 16'hA001) begin bad++; $display("FAIL stall_head3 got=%h exp=a001", bus.out_instr); end
    drive(1'b0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_no_comb_ready got=%b exp=0", bus.in_ready); end
    tick();
    total++; if (bus.out_instr !== 16'hA002) begin bad++; $display("FAIL stall_pop1_head got=%h exp=a002", bus.out_instr); end
    total++; if (bus.out_nextPc !== 16'h0A04) begin bad++; $display("FAIL stall_pop1_pc got=%h exp=0a04", bus.out_nextPc); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_pop1_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL stall_pop1_count got=%0d exp=1", bus.count); end
`else
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_full got=%b exp=0", bus.in_ready); end
    drive(1'b1, 16'hA002, 16'h0A04);
    tick();
    total++; if (bus.out_instr !== 16'hA001) begin bad++; $display("FAIL stall_hold_head got=%h exp=a001", bus.out_instr); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_comb_ready got=%b exp=1", bus.in_ready); end
    tick();
    total++; if (bus.out_instr !== 16'hA002) begin bad++; $display("FAIL stall_replace_head got=%h exp=a002", bus.out_instr); end
    total++; if (bus.out_nextPc !== 16'h0A04) begin bad++; $display("FAIL stall_replace_pc got=%h exp=0a04", bus.out_nextPc); end
    total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL stall_replace_count got=%0d exp=1", bus.count); end
    drive(1'b0, 16'h0000, 16'h0000);
`endif
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hD001, 16'h0D02);
    tick();
`ifdef IFID_SKID_EN
    drive(1'b1, 16'hD002, 16'h0D04);
    tick();
    total++; if (bus.count !== 2'd2) begin bad++; $display("FAIL flush_fill_count got=%0d exp=2", bus.count); end
`else
    total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL flush_fill_count got=%0d exp=1", bus.count); end
`endif
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hB000, 16'h0B02);
    tick();
    bus.flush = 1'b0;
    total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_instr !== 16'h0800) begin bad++; $display("FAIL flush_nop got=%h exp=0800", bus.out_instr); end
    total++; if (bus.out_nextPc !== 16'h0000) begin bad++; $display("FAIL flush_pc got=%h exp=0000", bus.out_nextPc); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hC000, 16'h0C02);
    tick();
    total++; if (bus.out_instr !== 16'hC000) begin bad++; $display("FAIL flush_next_head got=%h exp=c000", bus.out_instr); end
    total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL flush_next_count got=%0d exp=1", bus.count); end
    drive(1'b0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    logic [15:0] pc;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h3000, 16'h4000);
    tick();
    total++; if (bus.out_instr !== 16'h3000) begin bad++; $display("FAIL wrap_first got=%h exp=3000", bus.out_instr); end
    for (int k = 1; k <= 10; k++) begin
      w  = 16'h3000 + 16'(k);
      pc = 16'h4000 + 16'(2 * k);
      drive(1'b1, w, pc);
      tick();
      total++; if (bus.out_instr !== w) begin bad++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", k, bus.out_instr, w); end
      total++; if (bus.out_nextPc !== pc) begin bad++; $display("FAIL wrap_nextPc[%0d] got=%h exp=%h", k, bus.out_nextPc, pc); end
      total++; if (bus.count !== 2'd1) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=1", k, bus.count); end
    end
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL wrap_drain_count got=%0d exp=0", bus.count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
